// File: rtl/spi_ctrl_engine_if.sv
// ---------------------------------------------------------------------------
// spi_ctrl_engine_if
// Bundles every non-clock signal of the SPI control engine: the control
// register word, the TX buffer read port, the SPI pins and the progress
// strobes that go back to the register block.
//   master modport : the engine itself
//   slave  modport : its environment (register block, TX buffer, SPI slave)
// Signals:
//   EN               global enable, everything freezes while low
//   REGISTRO_CONTROL bit0 SEND, bit1 STOP, bits[11:4] N_BYTES
//   DATA_IN          TX byte at DATA_ADDR (combinational buffer read)
//   MISO             SPI serial in
//   DATA_ADDR        index of the current TX byte
//   SCLK/MOSI/CS_N   SPI mode-0 pins
//   RX_DATA/RX_WE    received byte and its one-cycle valid strobe
//   NTX_INC          one-cycle pulse per completed byte
//   SEND_CLR         one-cycle pulse that clears SEND in the register
//   BUSY             engine is not idle
// ---------------------------------------------------------------------------
interface spi_ctrl_engine_if #(
   parameter int CNT_W = 8
);
   logic             EN;
   logic [31:0]      REGISTRO_CONTROL;
   logic [7:0]       DATA_IN;
   logic             MISO;
   logic [CNT_W-1:0] DATA_ADDR;
   logic             SCLK;
   logic             MOSI;
   logic             CS_N;
   logic [7:0]       RX_DATA;
   logic             RX_WE;
   logic             NTX_INC;
   logic             SEND_CLR;
   logic             BUSY;

   modport master (
      input  EN, REGISTRO_CONTROL, DATA_IN, MISO,
      output DATA_ADDR, SCLK, MOSI, CS_N, RX_DATA, RX_WE, NTX_INC, SEND_CLR, BUSY
   );

   modport slave (
      output EN, REGISTRO_CONTROL, DATA_IN, MISO,
      input  DATA_ADDR, SCLK, MOSI, CS_N, RX_DATA, RX_WE, NTX_INC, SEND_CLR, BUSY
   );
endinterface

// File: rtl/spi_ctrl_engine.sv
// ---------------------------------------------------------------------------
// spi_ctrl_engine
// Consumer side of the 32-bit control register. When SEND is seen it runs a
// job of N_BYTES SPI mode-0 transfers (MSB first), fetching each TX byte from
// the buffer at DATA_ADDR, returning each RX byte with RX_WE, pulsing NTX_INC
// per completed byte and SEND_CLR once when the job ends. STOP ends the job
// after the byte in flight; bytes are never truncated.
// Ports:
//   CLK    system clock, rising edge
//   RESET  synchronous, active-high reset
//   bus    spi_ctrl_engine_if.master (control word, buffer port, SPI pins,
//          progress strobes)
// Parameters:
//   DIV    SCLK half-period in CLK cycles (>= 1)
//   CNT_W  width of the byte counter / buffer address
// ---------------------------------------------------------------------------
module spi_ctrl_engine #(
   parameter int DIV   = 2,
   parameter int CNT_W = 8
) (
   input logic               CLK,
   input logic               RESET,
   spi_ctrl_engine_if.master bus
);

   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, NEXT, DONE} state_t;

   state_t           state, state_nxt;
   logic [DIV_W-1:0] div_cnt;
   logic [2:0]       bit_cnt;
   logic             sclk, mosi;
   logic [7:0]       tx_sr, rx_sr, rx_data;
   logic [CNT_W-1:0] addr, nb;

   logic             en, send, stop;
   logic [7:0]       n_bytes;
   logic             half_end, byte_end, last_byte;
   logic [CNT_W:0]   addr_inc;
   logic             cs_n, busy, rx_we, ntx_inc, send_clr;
   logic             unused_ctrl;

   assign en      = bus.EN;
   assign send    = bus.REGISTRO_CONTROL[0];
   assign stop    = bus.REGISTRO_CONTROL[1];
   assign n_bytes = bus.REGISTRO_CONTROL[11:4];
   assign unused_ctrl = ^{bus.REGISTRO_CONTROL[31:12], bus.REGISTRO_CONTROL[3:2]};

   assign half_end  = (div_cnt == DIV_W'(DIV - 1));
   // Final edge of the byte: end of bit 7's high half.
   assign byte_end  = half_end && sclk && (bit_cnt == 3'd7);
   // One extra bit so that nb == 2**CNT_W - 1 compares without wrapping.
   assign addr_inc  = {1'b0, addr} + 1'b1;
   assign last_byte = (addr_inc == {1'b0, nb});

   // NOTE: every output of this block gets a default before the case so no
   // path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      cs_n      = 1'b1;
      busy      = 1'b1;
      rx_we     = 1'b0;
      ntx_inc   = 1'b0;
      send_clr  = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (send) state_nxt = (stop || n_bytes == 8'd0) ? DONE : LOAD;
         end
         LOAD: begin
            cs_n      = 1'b0;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            cs_n = 1'b0;
            if (byte_end) state_nxt = NEXT;
         end
         NEXT: begin
            cs_n      = 1'b0;
            // Strobes are qualified by EN so a frozen NEXT cannot count twice.
            rx_we     = en;
            ntx_inc   = en;
            state_nxt = (last_byte || stop) ? DONE : LOAD;
         end
         DONE: begin
            send_clr  = en;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge CLK) begin
      if (RESET)   state <= IDLE;
      else if (en) state <= state_nxt;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         div_cnt <= '0;
         bit_cnt <= '0;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
         tx_sr   <= '0;
         rx_sr   <= '0;
         rx_data <= '0;
         addr    <= '0;
         nb      <= '0;
      end else if (en) begin
         case (state)
            IDLE: begin
               if (state_nxt == LOAD) begin
                  nb   <= CNT_W'(n_bytes);
                  addr <= '0;
               end
            end
            LOAD: begin
               tx_sr   <= bus.DATA_IN;
               mosi    <= bus.DATA_IN[7];
               bit_cnt <= '0;
               div_cnt <= '0;
               sclk    <= 1'b0;
            end
            SHIFT: begin
               if (half_end) begin
                  div_cnt <= '0;
                  if (!sclk) begin
                     sclk  <= 1'b1;
                     rx_sr <= {rx_sr[6:0], bus.MISO};
                  end else begin
                     sclk <= 1'b0;
                     if (bit_cnt == 3'd7) begin
                        // Loaded on entry to NEXT so it is valid with RX_WE.
                        rx_data <= rx_sr;
                     end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        tx_sr   <= {tx_sr[6:0], 1'b0};
                        mosi    <= tx_sr[6];
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            NEXT: begin
               if (state_nxt == LOAD) addr <= addr + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.DATA_ADDR = addr;
   assign bus.SCLK      = sclk;
   assign bus.MOSI      = mosi;
   assign bus.CS_N      = cs_n;
   assign bus.RX_DATA   = rx_data;
   assign bus.RX_WE     = rx_we;
   assign bus.NTX_INC   = ntx_inc;
   assign bus.SEND_CLR  = send_clr;
   assign bus.BUSY      = busy;

endmodule

// File: doc/spi_ctrl_engine.md
Name: spi_ctrl_engine

Overview:
- Consumer side of the 32-bit control register: reads SEND/STOP/byte-count fields from REGISTRO_CONTROL and runs SPI mode-0 master transfers.
- Reports progress back to the register block: one-cycle NTX_INC per completed byte, one-cycle SEND_CLR when the job ends.
- Sits between the control register, the TX byte buffer and the SPI pins.

Parameters:
- DIV, 2, SCLK half-period in CLK cycles (DIV>=1); SCLK period = 2*DIV cycles.
- CNT_W, 8, width of the byte counter and the buffer address.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- EN  in  1  global enable; when low, all state, counters and outputs hold.
- REGISTRO_CONTROL  in  32  bit0 SEND, bit1 STOP, bits[11:4] N_BYTES, other bits ignored.
- DATA_IN  in  8  TX byte at DATA_ADDR; combinational read from the buffer.
- MISO  in  1  SPI serial in.
- DATA_ADDR  out  CNT_W  index of the current TX byte.
- SCLK  out  1  SPI clock, idles low.
- MOSI  out  1  SPI serial out, MSB first.
- CS_N  out  1  chip select, active low.
- RX_DATA  out  8  last received byte.
- RX_WE  out  1  one-cycle strobe, RX_DATA valid.
- NTX_INC  out  1  one-cycle pulse per completed byte, increments N_TX in the register.
- SEND_CLR  out  1  one-cycle pulse that clears SEND in the register.
- BUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset values: SCLK=0, MOSI=0, CS_N=1, RX_DATA=0, RX_WE=0, NTX_INC=0, SEND_CLR=0, BUSY=0, DATA_ADDR=0, state IDLE.
- Reset mid-transfer aborts on the same edge. No SEND_CLR or NTX_INC is issued.
- States: IDLE, LOAD, SHIFT, NEXT, DONE.
- IDLE -> LOAD: requires EN & SEND & !STOP & N_BYTES!=0.
  - On entry: latch N_BYTES into nb and set DATA_ADDR=0.
- IDLE -> DONE: requires EN & SEND & (STOP | N_BYTES==0). No SPI activity occurs.
- LOAD (1 cycle):
  - CS_N=0, BUSY=1.
  - Shift register <= DATA_IN; MOSI <= DATA_IN[7].
  - Bit counter = 0. Go to SHIFT.
- SHIFT (16*DIV cycles per byte):
  - Each bit spends DIV cycles with SCLK=0, then DIV cycles with SCLK=1.
  - MISO is sampled into the RX shift register on the edge where SCLK goes 0->1.
  - On the edge where SCLK goes 1->0, MOSI advances to the next bit.
  - After bit 7's high half: SCLK=0, go to NEXT.
- NEXT (1 cycle):
  - RX_DATA <= RX shift register. RX_WE=1 and NTX_INC=1 for this cycle.
  - If DATA_ADDR+1==nb or STOP=1: go to DONE. Otherwise DATA_ADDR++ and go to LOAD.
- DONE (1 cycle): CS_N=1, SEND_CLR=1, then go to IDLE.
  - The register clears SEND on the same edge, so IDLE does not retrigger.
  - If SEND is still high in IDLE, a new job starts. This is the intended back-to-back behaviour.
- STOP during SHIFT: the current byte completes, then NEXT -> DONE. Bytes are never truncated.
- Changes to REGISTRO_CONTROL fields after job start are ignored, except STOP. nb is latched.
- N_BYTES=255 with CNT_W=8: DATA_ADDR runs 0..254 with no wrap. CS_N stays low across all bytes.
- EN low in any state freezes everything, including the divider phase and SCLK level. Resumes exactly on EN high.
- Per-job latency in cycles (EN held high):
  - Job start: 1 (IDLE->LOAD).
  - Per byte: N*(16*DIV+2).
  - Job end: 1 (DONE).

Test Plan:
- Reset with DIV=2:
  - Stimulus: reset, then REGISTRO_CONTROL=0x011 (SEND, N=1), DATA_IN=0xA5, MISO driven 0x3C MSB-first.
  - Response: CS_N low for 34 cycles; 8 SCLK pulses of 4 cycles each.
  - Response: MOSI shows 1,0,1,0,0,1,0,1.
  - Response: RX_DATA=0x3C with RX_WE and NTX_INC for 1 cycle, then SEND_CLR for 1 cycle, BUSY=0 after.
- N=3 with buffer {0x01,0x02,0x03}:
  - Response: DATA_ADDR steps 0,1,2; three NTX_INC pulses; one SEND_CLR; CS_N stays low continuously.
  - Response: total BUSY = 3*34+1 = 103 cycles.
- STOP raised mid-byte 0 of an N=4 job:
  - Response: byte 0 completes; exactly one NTX_INC; then SEND_CLR; no LOAD for byte 1.
- N_BYTES=0 or STOP=1 with SEND:
  - Response: DONE directly; SEND_CLR for 1 cycle; CS_N never low; no NTX_INC.
- EN dropped for 5 cycles mid-SHIFT:
  - Response: SCLK, MOSI and counters hold; after EN returns, the remaining timing is unchanged and the total is extended by exactly 5 cycles.
- RESET asserted mid-byte:
  - Response: next cycle CS_N=1, SCLK=0, BUSY=0; no SEND_CLR, RX_WE or NTX_INC pulses.
